dcf77_time_decoder: RTL
=======================

Name: dcf77_time_decoder

Overview:
- Downstream stage of the DCF77 pulse encoder. Consumes its per-minute frame strobe and 59-bit frame.
- Validates markers, parity and field ranges, and checks plausibility against the previous frame (minute continuity).
- Presents BCD date/time plus a free-running seconds count to the SpartanMC peripheral wrapper.
- Asserts a lock flag once enough consecutive consistent frames are seen.

Parameters:
- CLOCK_FREQUENCY, 16000000: clk frequency in Hz; sets the 1 s tick divider.
- LOCK_FRAMES, 2: consecutive plausible frames required before time_valid rises (1..7).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- dcf_sec  in  1  one-cycle strobe: new frame present on dcf_bits
- dcf_bits  in  59  frame; bit k = DCF second k (bit 0 = second 0)
- minute  out  7  BCD {tens[2:0], units[3:0]}
- hour  out  6  BCD {tens[1:0], units}
- day  out  6  BCD {tens[1:0], units}
- weekday  out  3  1=Mon..7=Sun
- month  out  5  BCD {tens[0], units}
- year  out  8  BCD, 2-digit
- dst  out  1  1 = CEST (frame bit 17)
- second  out  6  binary 0..59, local count since last accepted frame
- time_valid  out  1  level: locked
- time_update  out  1  one-cycle pulse when time fields are updated
- frame_error  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset (reset_n low, async): all outputs 0. FSM = IDLE. Lock count, tick divider and internal second count cleared.
- Frame bit map (decided): 0 = 0, 17 = CEST, 18 = CET, 20 = 1, 21-24 min units, 25-27 min tens, 28 P1, 29-32 hr units, 33-34 hr tens, 35 P2, 36-39 day units, 40-41 day tens, 42-44 weekday, 45-48 month units, 49 month tens, 50-53 yr units, 54-57 yr tens, 58 P3.
- FSM IDLE -> CHECK -> COMPARE -> UPDATE -> IDLE, one cycle per state.
  - IDLE: on dcf_sec=1, latch dcf_bits into frame register, go to CHECK. dcf_sec in any other state is ignored.
  - CHECK: format_ok is the AND of:
    - bit0 == 0 and bit20 == 1
    - bit17 XOR bit18 == 1
    - even parity over 21..28, 29..35 and 36..58
    - every BCD digit <= 9
    - minute <= 59, hour <= 23, day 01..31, month 01..12, weekday 1..7
  - COMPARE: plausible = format_ok AND previous accepted frame exists AND new (hour:minute) == previous + 1 min.
    - BCD increment; 59 wraps to 00 with hour carry, 23:59 wraps to 00:00.
    - Date, weekday and year must equal previous unless the hour wrapped; if wrapped, date is not compared.
    - Previous is kept internally even while unlocked.
  - UPDATE:
    - format_ok=0: lock count cleared, time_valid 0, previous-exists cleared, frame_error pulse. Outputs keep old values.
    - format_ok=1: time outputs and dst loaded, previous := new, time_update pulse, tick divider and second reset to 0.
    - Lock count becomes plausible ? min(cnt+1, LOCK_FRAMES) : 1. time_valid = (count >= LOCK_FRAMES).
- Latency: dcf_sec sampled high at edge N; outputs and pulses are visible after edge N+3, with pulses high for exactly one cycle.
- Seconds:
  - Divider counts 0..CLOCK_FREQUENCY-1; each wrap increments an internal 7-bit second counter.
  - The second output shows min(internal, 59), so it holds at 59 through a leap second.
  - When internal reaches 62 with no accepted frame: time_valid 0, lock count 0, previous-exists cleared, counter saturates at 62.
- Reset mid-operation: immediate return to reset state; a partially processed frame is discarded.

Decomposition:
- Package dcf77_pkg holds:
  - bit-position localparams (e.g. DCF_MIN_U_LO=21)
  - field widths
  - FSM state encoding (IDLE, CHECK, COMPARE, UPDATE)
  - SECOND_TIMEOUT=62
- Sub-module dcf77_bcd_minute_inc: combinational BCD (hour, minute) + 1 with wrap flag, used by COMPARE.

Test Plan:
- Valid frame 12:34 CET, 15.06.24, Sat (wd 6), correct parities; dcf_sec at edge N -> at N+3 minute=0x34, hour=0x12, day=0x15, month=0x06, year=0x24, weekday=6, dst=0, time_update pulse, time_valid=0 with LOCK_FRAMES=2.
- Follow-up frame 12:35, otherwise identical -> time_valid=1, second=0 after edge N+3.
- Follow-up frame with P1 flipped -> frame_error pulse, time_valid=0, minute stays 0x35, no time_update.
- Locked at 23:59 31.12.24 with LOCK_FRAMES=2, next frame 00:00 01.01.25 -> accepted as plausible, time_valid stays 1, day=0x01, year=0x25.
- Locked, then no dcf_sec with CLOCK_FREQUENCY=1000 -> second holds 59 from 59 s onward, time_valid falls at 62000 cycles after last update.
- Frame with minute=0x5A or bit20=0 -> frame_error, lock cleared. Also: reset_n pulsed low during CHECK -> all outputs 0 immediately, no time_update.

Source files
------------

// File: rtl/dcf77_pkg.sv
// Shared constants for the DCF77 time decoder: frame bit positions, field
// widths, FSM encoding and the second-count timeout.
package dcf77_pkg;

  localparam int DCF_FRAME_W  = 59;

  localparam int DCF_START    = 0;
  localparam int DCF_CEST     = 17;
  localparam int DCF_CET      = 18;
  localparam int DCF_TSTART   = 20;
  localparam int DCF_MIN_U_LO = 21;
  localparam int DCF_P1       = 28;
  localparam int DCF_HR_U_LO  = 29;
  localparam int DCF_P2       = 35;
  localparam int DCF_DAY_U_LO = 36;
  localparam int DCF_WD_LO    = 42;
  localparam int DCF_MON_U_LO = 45;
  localparam int DCF_YR_U_LO  = 50;
  localparam int DCF_P3       = 58;

  localparam int MIN_W = 7;
  localparam int HR_W  = 6;
  localparam int DAY_W = 6;
  localparam int WD_W  = 3;
  localparam int MON_W = 5;
  localparam int YR_W  = 8;

  localparam logic [6:0] SECOND_TIMEOUT   = 7'd62;
  localparam logic [6:0] SECOND_SHOWN_MAX = 7'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    COMPARE = 2'd2,
    UPDATE  = 2'd3
  } dcf_state_t;

  function automatic logic bcd_ok(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/dcf77_time_decoder_bcd_minute_inc.sv
// Combinational BCD (hour, minute) + 1 minute; day_wrap flags 23:59 -> 00:00.
module dcf77_bcd_minute_inc
  import dcf77_pkg::*;
(
  input  logic [HR_W-1:0]  hour,
  input  logic [MIN_W-1:0] minute,
  output logic [HR_W-1:0]  hour_next,
  output logic [MIN_W-1:0] minute_next,
  output logic             day_wrap
);

  always_comb begin
    hour_next   = hour;
    minute_next = minute;
    day_wrap    = 1'b0;
    if (minute[3:0] != 4'd9) begin
      minute_next = {minute[6:4], minute[3:0] + 4'd1};
    end else if (minute[6:4] != 3'd5) begin
      minute_next = {minute[6:4] + 3'd1, 4'd0};
    end else begin
      minute_next = '0;
      if (hour == 6'h23) begin
        hour_next = '0;
        day_wrap  = 1'b1;
      end else if (hour[3:0] == 4'd9) begin
        hour_next = {hour[5:4] + 2'd1, 4'd0};
      end else begin
        hour_next = {hour[5:4], hour[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/dcf77_time_decoder.sv
// DCF77 frame validator: checks format and minute continuity, presents BCD
// time, a local seconds count and a lock flag after consecutive good frames.
module dcf77_time_decoder
  import dcf77_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 16000000,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dcf_sec,
  input  logic [58:0] dcf_bits,
  output logic [6:0]  minute,
  output logic [5:0]  hour,
  output logic [5:0]  day,
  output logic [2:0]  weekday,
  output logic [4:0]  month,
  output logic [7:0]  year,
  output logic        dst,
  output logic [5:0]  second,
  output logic        time_valid,
  output logic        time_update,
  output logic        frame_error
);

  localparam int               DIV_W    = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLOCK_FREQUENCY - 1);
  localparam logic [2:0]       LOCK_MAX = 3'(LOCK_FRAMES);

  dcf_state_t state_reg, state_next;

  logic [DCF_FRAME_W-1:0] frame_reg;
  logic                   format_ok_reg;
  logic                   plausible_reg;
  logic                   prev_valid_reg;
  logic [MIN_W-1:0]       prev_minute_reg;
  logic [HR_W-1:0]        prev_hour_reg;
  logic [DAY_W-1:0]       prev_day_reg;
  logic [WD_W-1:0]        prev_weekday_reg;
  logic [MON_W-1:0]       prev_month_reg;
  logic [YR_W-1:0]        prev_year_reg;

  logic [MIN_W-1:0] minute_reg;
  logic [HR_W-1:0]  hour_reg;
  logic [DAY_W-1:0] day_reg;
  logic [WD_W-1:0]  weekday_reg;
  logic [MON_W-1:0] month_reg;
  logic [YR_W-1:0]  year_reg;
  logic             dst_reg;
  logic             time_valid_reg;
  logic             time_update_reg;
  logic             frame_error_reg;
  logic [2:0]       lock_cnt_reg;
  logic [2:0]       lock_cnt_next;
  logic [DIV_W-1:0] div_reg;
  logic [6:0]       sec_reg;

  logic [MIN_W-1:0] f_minute;
  logic [HR_W-1:0]  f_hour;
  logic [DAY_W-1:0] f_day;
  logic [WD_W-1:0]  f_weekday;
  logic [MON_W-1:0] f_month;
  logic [YR_W-1:0]  f_year;
  logic             markers_ok, parity_ok, digits_ok, range_ok, format_ok_next;
  logic [HR_W-1:0]  inc_hour;
  logic [MIN_W-1:0] inc_minute;
  logic             inc_day_wrap;
  logic             continuity;
  logic             tick;
  logic             unused_frame_bits;

  assign f_minute  = frame_reg[DCF_MIN_U_LO +: MIN_W];
  assign f_hour    = frame_reg[DCF_HR_U_LO  +: HR_W];
  assign f_day     = frame_reg[DCF_DAY_U_LO +: DAY_W];
  assign f_weekday = frame_reg[DCF_WD_LO    +: WD_W];
  assign f_month   = frame_reg[DCF_MON_U_LO +: MON_W];
  assign f_year    = frame_reg[DCF_YR_U_LO  +: YR_W];

  // Civil-warning and reserved bits carry nothing this block decodes.
  assign unused_frame_bits = ^{frame_reg[16:1], frame_reg[19]};

  assign markers_ok = ~frame_reg[DCF_START] & frame_reg[DCF_TSTART]
                    & (frame_reg[DCF_CEST] ^ frame_reg[DCF_CET]);
  assign parity_ok  = ~(^frame_reg[DCF_P1:DCF_MIN_U_LO])
                    & ~(^frame_reg[DCF_P2:DCF_HR_U_LO])
                    & ~(^frame_reg[DCF_P3:DCF_DAY_U_LO]);
  assign digits_ok  = bcd_ok(f_minute[3:0]) & bcd_ok(f_hour[3:0]) & bcd_ok(f_day[3:0])
                    & bcd_ok(f_month[3:0]) & bcd_ok(f_year[3:0]) & bcd_ok(f_year[7:4]);
  // With valid digits, BCD codes order like the values they encode.
  assign range_ok   = (f_minute <= 7'h59) & (f_hour <= 6'h23)
                    & (f_day != '0) & (f_day <= 6'h31)
                    & (f_month != '0) & (f_month <= 5'h12)
                    & (f_weekday != '0);
  assign format_ok_next = markers_ok & parity_ok & digits_ok & range_ok;

  dcf77_bcd_minute_inc u_minute_inc (
    .hour        (prev_hour_reg),
    .minute      (prev_minute_reg),
    .hour_next   (inc_hour),
    .minute_next (inc_minute),
    .day_wrap    (inc_day_wrap)
  );

  assign continuity = (f_hour == inc_hour) && (f_minute == inc_minute)
                   && (inc_day_wrap || ((f_day == prev_day_reg) && (f_weekday == prev_weekday_reg)
                                     && (f_month == prev_month_reg) && (f_year == prev_year_reg)));

  assign tick          = (div_reg == DIV_MAX);
  assign lock_cnt_next = !plausible_reg ? 3'd1
                       : (lock_cnt_reg >= LOCK_MAX) ? LOCK_MAX : lock_cnt_reg + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (dcf_sec) state_next = CHECK;
      CHECK:   state_next = COMPARE;
      COMPARE: state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_reg        <= '0;
      format_ok_reg    <= 1'b0;
      plausible_reg    <= 1'b0;
      prev_valid_reg   <= 1'b0;
      prev_minute_reg  <= '0;
      prev_hour_reg    <= '0;
      prev_day_reg     <= '0;
      prev_weekday_reg <= '0;
      prev_month_reg   <= '0;
      prev_year_reg    <= '0;
      minute_reg       <= '0;
      hour_reg         <= '0;
      day_reg          <= '0;
      weekday_reg      <= '0;
      month_reg        <= '0;
      year_reg         <= '0;
      dst_reg          <= 1'b0;
      time_valid_reg   <= 1'b0;
      time_update_reg  <= 1'b0;
      frame_error_reg  <= 1'b0;
      lock_cnt_reg     <= '0;
      div_reg          <= '0;
      sec_reg          <= '0;
    end else begin
      time_update_reg <= 1'b0;
      frame_error_reg <= 1'b0;

      if (state_reg == IDLE && dcf_sec) frame_reg <= dcf_bits;
      if (state_reg == CHECK) format_ok_reg <= format_ok_next;
      if (state_reg == COMPARE) plausible_reg <= format_ok_reg & prev_valid_reg & continuity;

      if (tick) begin
        div_reg <= '0;
        if (sec_reg < SECOND_TIMEOUT) sec_reg <= sec_reg + 7'd1;
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end

      // Signal loss: no accepted frame for too long drops lock and history.
      if (tick && sec_reg == SECOND_TIMEOUT - 7'd1) begin
        time_valid_reg <= 1'b0;
        lock_cnt_reg   <= '0;
        prev_valid_reg <= 1'b0;
      end

      if (state_reg == UPDATE) begin
        if (!format_ok_reg) begin
          lock_cnt_reg    <= '0;
          time_valid_reg  <= 1'b0;
          prev_valid_reg  <= 1'b0;
          frame_error_reg <= 1'b1;
        end else begin
          minute_reg       <= f_minute;
          hour_reg         <= f_hour;
          day_reg          <= f_day;
          weekday_reg      <= f_weekday;
          month_reg        <= f_month;
          year_reg         <= f_year;
          dst_reg          <= frame_reg[DCF_CEST];
          prev_valid_reg   <= 1'b1;
          prev_minute_reg  <= f_minute;
          prev_hour_reg    <= f_hour;
          prev_day_reg     <= f_day;
          prev_weekday_reg <= f_weekday;
          prev_month_reg   <= f_month;
          prev_year_reg    <= f_year;
          time_update_reg  <= 1'b1;
          div_reg          <= '0;
          sec_reg          <= '0;
          lock_cnt_reg     <= lock_cnt_next;
          time_valid_reg   <= (lock_cnt_next >= LOCK_MAX);
        end
      end
    end
  end

  assign minute      = minute_reg;
  assign hour        = hour_reg;
  assign day         = day_reg;
  assign weekday     = weekday_reg;
  assign month       = month_reg;
  assign year        = year_reg;
  assign dst         = dst_reg;
  assign second      = (sec_reg > SECOND_SHOWN_MAX) ? 6'd59 : sec_reg[5:0];
  assign time_valid  = time_valid_reg;
  assign time_update = time_update_reg;
  assign frame_error = frame_error_reg;

endmodule
